// File: rtl/uart_tx_scheduler_pkg.sv
// uart_sched_pkg: shared types for the UART TX packet scheduler.
// Holds the FSM state enum, default header magic and an index helper.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_HDR,
      S_WAIT_HDR,
      S_FETCH,
      S_SEND_DATA,
      S_WAIT_DATA
   } sched_state_t;

   localparam logic [3:0] HDR_MAGIC_DEFAULT = 4'hA;

   // Modulo reduction for a < 2n, used by the round-robin search.
   function automatic int wrap_idx(input int a, input int n);
      return (a >= n) ? (a - n) : a;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_arb.sv
// rr_arbiter: combinational round-robin pick starting after last_in.
// Ports: req_in (requests), last_in (previous winner index),
//        gnt_out (one-hot), idx_out (encoded), any_out (any request).
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_in,
   input  logic [IW-1:0] last_in,
   output logic [N-1:0]  gnt_out,
   output logic [IW-1:0] idx_out,
   output logic          any_out
);

   int w_cand;

   // Walk last+1 .. last+N; the first requester hit wins.
   always_comb begin
      gnt_out = '0;
      idx_out = '0;
      any_out = 1'b0;
      w_cand  = 0;
      for (int k = 1; k <= N; k++) begin
         w_cand = wrap_idx(int'(last_in) + k, N);
         if (!any_out && req_in[w_cand[IW-1:0]]) begin
            any_out                  = 1'b1;
            gnt_out[w_cand[IW-1:0]] = 1'b1;
            idx_out                  = w_cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: packet round-robin sharing one uart_tx serializer.
// Ports: clk_in, rst_n_in (async low); req_valid_in/req_data_in/
//   req_last_in/req_ready_out per requester; grant_out, busy_out status;
//   tx_data_out/tx_enable_out to uart_tx, tx_busy_in/tx_done_in back.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int         NUM_REQ   = 4,
   parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [NUM_REQ-1:0]   req_valid_in,
   input  logic [8*NUM_REQ-1:0] req_data_in,
   input  logic [NUM_REQ-1:0]   req_last_in,
   output logic [NUM_REQ-1:0]   req_ready_out,
   output logic [NUM_REQ-1:0]   grant_out,
   output logic                 busy_out,
   output logic [7:0]           tx_data_out,
   output logic                 tx_enable_out,
   input  logic                 tx_busy_in,
   input  logic                 tx_done_in
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IW-1:0] LG_RST = IW'(NUM_REQ - 1);

   sched_state_t         r_state;
   sched_state_t         w_state_nx;
   logic [NUM_REQ-1:0]   r_grant;
   logic [NUM_REQ-1:0]   w_grant_nx;
   logic [IW-1:0]        r_gidx;
   logic [IW-1:0]        w_gidx_nx;
   logic [IW-1:0]        r_lgnt;
   logic [IW-1:0]        w_lgnt_nx;
   logic [7:0]           r_data;
   logic [7:0]           w_data_nx;
   logic                 r_last;
   logic                 w_last_nx;
   logic                 r_enable;
   logic                 w_enable_nx;
   logic [NUM_REQ-1:0]   w_ready;

   logic [NUM_REQ-1:0]   w_arb_gnt;
   logic [IW-1:0]        w_arb_idx;
   logic                 w_arb_any;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req_in  (req_valid_in),
      .last_in (r_lgnt),
      .gnt_out (w_arb_gnt),
      .idx_out (w_arb_idx),
      .any_out (w_arb_any)
   );

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_gidx_nx  = r_gidx;
      w_lgnt_nx  = r_lgnt;
      w_data_nx  = r_data;
      w_last_nx  = r_last;
      w_ready    = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_arb_any) begin
               w_grant_nx = w_arb_gnt;
               w_gidx_nx  = w_arb_idx;
               w_lgnt_nx  = w_arb_idx;
               w_data_nx  = {HDR_MAGIC, 4'(w_arb_idx)};
               w_state_nx = S_SEND_HDR;
            end
         end
         S_SEND_HDR: begin
            if (tx_busy_in) w_state_nx = S_WAIT_HDR;
         end
         S_WAIT_HDR: begin
            if (tx_done_in) w_state_nx = S_FETCH;
         end
         S_FETCH: begin
            // Ready is combinational so the byte is taken the cycle
            // valid is first seen.
            if (req_valid_in[r_gidx]) begin
               w_ready[r_gidx] = 1'b1;
               w_data_nx  = req_data_in[{r_gidx, 3'b000} +: 8];
               w_last_nx  = req_last_in[r_gidx];
               w_state_nx = S_SEND_DATA;
            end
         end
         S_SEND_DATA: begin
            if (tx_busy_in) w_state_nx = S_WAIT_DATA;
         end
         S_WAIT_DATA: begin
            if (tx_done_in) begin
               if (r_last) begin
                  w_grant_nx = '0;
                  w_state_nx = S_IDLE;
               end else begin
                  w_state_nx = S_FETCH;
               end
            end
         end
         default: begin
            w_grant_nx = '0;
            w_state_nx = S_IDLE;
         end
      endcase
      w_enable_nx = (w_state_nx == S_SEND_HDR) ||
                    (w_state_nx == S_SEND_DATA);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_gidx   <= '0;
         r_lgnt   <= LG_RST;
         r_data   <= '0;
         r_last   <= 1'b0;
         r_enable <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_grant  <= w_grant_nx;
         r_gidx   <= w_gidx_nx;
         r_lgnt   <= w_lgnt_nx;
         r_data   <= w_data_nx;
         r_last   <= w_last_nx;
         r_enable <= w_enable_nx;
      end
   end

   assign req_ready_out = w_ready;
   assign grant_out     = r_grant;
   assign busy_out      = (r_state != S_IDLE);
   assign tx_data_out   = r_data;
   assign tx_enable_out = r_enable;

endmodule
